core_inst_sequencer: RTL

// Hardware instruction sequencer that drives the 34-bit inst bus of `core`. It replaces

---
 rtl/core_inst_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for `core`: steps weight fetch, L0 fill, PE load, execute and OFIFO
// drain for every kij, then accumulates the psums per output pixel. All outputs are registered.
module core_inst_sequencer #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int in_w     = 6,
    parameter int k_w      = 3,
    parameter int wgt_base = 1024,
    parameter int gap_cyc  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        core_reset,
    output logic [3:0]  kij,
    output logic        out_valid,
    output logic [3:0]  onij,
    output logic        busy,
    output logic        done
);
    localparam int LEN_NIJ  = in_w * in_w;
    localparam int LEN_KIJ  = k_w * k_w;
    localparam int OUT_W    = in_w - k_w + 1;
    localparam int LEN_ONIJ = OUT_W * OUT_W;
    localparam int EXEC_CYC = LEN_NIJ + row + col;
    localparam int ACC_CYC  = LEN_KIJ + 3;  // reads, trailing acc, acc=0 gap, out_valid

    typedef struct packed {
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam inst_t INST_IDLE = inst_t'(34'h1_800C_0000);

    typedef enum logic [3:0] {
        S_IDLE, S_CRST, S_W_L0, S_LOAD, S_GAP, S_X_L0,
        S_EXEC, S_WAIT_OF, S_DRAIN, S_ACC, S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_kij, w_kij_nxt;
    logic [3:0] r_onij, w_onij_nxt;
    logic       w_last;

    inst_t      r_inst, w_inst;
    logic       r_core_reset, w_core_reset;
    logic       r_out_valid, w_out_valid;
    logic       r_busy, w_busy;
    logic       r_done, w_done;

    always_comb begin
        int v_len;
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 7'd1;
        w_kij_nxt   = r_kij;
        w_onij_nxt  = r_onij;
        case (r_state)
            S_CRST:  v_len = 2;
            S_W_L0:  v_len = col + 1;
            S_LOAD:  v_len = col;
            S_GAP:   v_len = gap_cyc;
            S_X_L0:  v_len = LEN_NIJ + 1;
            S_EXEC:  v_len = EXEC_CYC;
            S_DRAIN: v_len = LEN_NIJ;
            S_ACC:   v_len = ACC_CYC;
            default: v_len = 1;
        endcase
        w_last = (int'(r_cnt) == v_len - 1);

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt = S_CRST;
                    w_kij_nxt   = '0;
                    w_onij_nxt  = '0;
                end
            end
            S_CRST:  if (w_last) begin w_state_nxt = S_W_L0; w_cnt_nxt = '0; end
            S_W_L0:  if (w_last) begin w_state_nxt = S_LOAD; w_cnt_nxt = '0; end
            S_LOAD:  if (w_last) begin w_state_nxt = S_GAP;  w_cnt_nxt = '0; end
            S_GAP:   if (w_last) begin w_state_nxt = S_X_L0; w_cnt_nxt = '0; end
            S_X_L0:  if (w_last) begin w_state_nxt = S_EXEC; w_cnt_nxt = '0; end
            S_EXEC:  if (w_last) begin w_state_nxt = S_WAIT_OF; w_cnt_nxt = '0; end
            S_WAIT_OF: begin
                w_cnt_nxt = '0;
                if (ofifo_valid) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (int'(r_kij) == LEN_KIJ - 1) begin
                        w_state_nxt = S_ACC;
                        w_onij_nxt  = '0;
                    end else begin
                        w_state_nxt = S_CRST;
                        w_kij_nxt   = r_kij + 4'd1;
                    end
                end
            end
            S_ACC: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (int'(r_onij) == LEN_ONIJ - 1) w_state_nxt = S_DONE;
                    else                              w_onij_nxt  = r_onij + 4'd1;
                end
            end
            S_DONE:  begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
            default: begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with r_state.
    always_comb begin
        int v_c, v_k, v_o;
        v_c          = int'(w_cnt_nxt);
        v_k          = int'(w_kij_nxt);
        v_o          = int'(w_onij_nxt);
        w_inst       = INST_IDLE;
        w_core_reset = 1'b0;
        w_out_valid  = 1'b0;
        w_done       = 1'b0;
        w_busy       = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_CRST: w_core_reset = 1'b1;
            S_W_L0: begin
                if (v_c < col) begin
                    w_inst.cen_xmem = 1'b0;
                    w_inst.a_xmem   = 11'(wgt_base + v_k * col + v_c);
                end
                w_inst.l0_wr = (v_c != 0);
            end
            S_LOAD: begin
                w_inst.l0_rd = 1'b1;
                w_inst.load  = 1'b1;
            end
            S_X_L0: begin
                if (v_c < LEN_NIJ) begin
                    w_inst.cen_xmem = 1'b0;
                    w_inst.a_xmem   = 11'(v_c);
                end
                w_inst.l0_wr = (v_c != 0);
            end
            S_EXEC: begin
                w_inst.l0_rd   = (v_c < LEN_NIJ);
                w_inst.execute = (v_c < LEN_NIJ);
            end
            S_DRAIN: begin
                w_inst.cen_pmem = 1'b0;
                w_inst.wen_pmem = 1'b0;
                w_inst.a_pmem   = 11'(v_k * LEN_NIJ + v_c);
                w_inst.ofifo_rd = 1'b1;
            end
            S_ACC: begin
                // During ACC the count walks the kernel offsets k = ki*k_w + kj.
                if (v_c < LEN_KIJ) begin
                    w_inst.cen_pmem = 1'b0;
                    w_inst.a_pmem   = 11'(v_c * LEN_NIJ + (v_o / OUT_W + v_c / k_w) * in_w
                                          + v_o % OUT_W + v_c % k_w);
                end
                w_inst.acc  = (v_c >= 1) && (v_c <= LEN_KIJ);
                w_out_valid = (v_c == ACC_CYC - 1);
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_kij        <= '0;
            r_onij       <= '0;
            r_inst       <= INST_IDLE;
            r_core_reset <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_kij        <= w_kij_nxt;
            r_onij       <= w_onij_nxt;
            r_inst       <= w_inst;
            r_core_reset <= w_core_reset;
            r_out_valid  <= w_out_valid;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    assign inst       = r_inst;
    assign core_reset = r_core_reset;
    assign kij        = r_kij;
    assign out_valid  = r_out_valid;
    assign onij       = r_onij;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
